// File: rtl/rr_prio_arbiter.sv
// N-way request arbiter with registered, locking one-hot grants.
// Round-robin or fixed priority, held until release or an optional hold timeout.
module rr_prio_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MODE     = 1,
  parameter int unsigned HOLD_MAX = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N-1:0]                         req_i,
  input  logic                                 release_i,
  output logic [N-1:0]                         gnt_o,
  output logic                                 gnt_valid_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_id_o,
  output logic                                 timeout_o
);

  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic [N-1:0]   elig;
  logic           found;
  logic [IDW-1:0] win;
  int unsigned    idx;
  logic           timeout_c;
  logic           end_evt;
  logic           new_grant;

  // The current owner is excluded when it hands over, so another requester gets a turn.
  assign elig    = (state_q == GRANT) ? (req_i & ~gnt_q) : req_i;
  assign end_evt = release_i | timeout_c;

  // Scan from ptr upward with wrap; first eligible bit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned o = 0; o < N; o++) begin
      idx = (32'(ptr_q) + o) % N;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    new_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) new_grant = 1'b1;
      end
      GRANT: begin
        if (end_evt) begin
          if (found) begin
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (new_grant) begin
      state_d = GRANT;
      gnt_d   = N'(1) << win;
      id_d    = win;
      if (MODE != 0) ptr_d = (win == IDW'(N - 1)) ? '0 : win + IDW'(1);
    end
  end

  always_comb begin
    gnt_o       = gnt_q;
    gnt_valid_o = (state_q == GRANT);
    gnt_id_o    = id_q;
    timeout_o   = timeout_c;
  end

  // Hold counter: cycles spent in the current grant, minus one.
  if (HOLD_MAX > 0) begin : g_hold
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (new_grant)             cnt_d = '0;
      else if (state_q == GRANT) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign timeout_c = (state_q == GRANT) && (cnt_q == CW'(HOLD_MAX - 1)) && !release_i;
  end else begin : g_no_hold
    assign timeout_c = 1'b0;
  end

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// Bench for rr_prio_arbiter: three configurations share one stimulus stream and are
// compared every cycle against a queue-free owner/pointer model, plus literal checkpoints.
module tb_rr_prio_arbiter;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i;
  logic       rel_i;

  logic [3:0] gnt_w [NDUT];
  logic       vld_w [NDUT];
  logic [1:0] id_w  [NDUT];
  logic       to_w  [NDUT];

  int n_chk  = 0;
  int n_fail = 0;

  // Model configuration: 0 = round-robin, 1 = fixed priority, 2 = round-robin with HOLD_MAX=3.
  int mode [NDUT] = '{1, 0, 1};
  int hm   [NDUT] = '{0, 0, 3};
  int own  [NDUT] = '{-1, -1, -1};
  int ptr  [NDUT] = '{0, 0, 0};
  int held [NDUT] = '{0, 0, 0};
  bit model_ok = 1'b0;

  always #5 clk = ~clk;

  rr_prio_arbiter #(.N(4), .MODE(1), .HOLD_MAX(0)) u_rr (
    .clk(clk), .rst(rst), .req_i(req_i), .release_i(rel_i),
    .gnt_o(gnt_w[0]), .gnt_valid_o(vld_w[0]), .gnt_id_o(id_w[0]), .timeout_o(to_w[0]));

  rr_prio_arbiter #(.N(4), .MODE(0), .HOLD_MAX(0)) u_fp (
    .clk(clk), .rst(rst), .req_i(req_i), .release_i(rel_i),
    .gnt_o(gnt_w[1]), .gnt_valid_o(vld_w[1]), .gnt_id_o(id_w[1]), .timeout_o(to_w[1]));

  rr_prio_arbiter #(.N(4), .MODE(1), .HOLD_MAX(3)) u_to (
    .clk(clk), .rst(rst), .req_i(req_i), .release_i(rel_i),
    .gnt_o(gnt_w[2]), .gnt_valid_o(vld_w[2]), .gnt_id_o(id_w[2]), .timeout_o(to_w[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] e, input int p);
    for (int o = 0; o < 4; o++) if (e[(p + o) % 4]) return (p + o) % 4;
    return -1;
  endfunction

  function automatic bit model_to(input int d);
    return (own[d] >= 0) && (hm[d] > 0) && (held[d] == hm[d]) && !rel_i;
  endfunction

  // Reference: who owns the resource, for how many cycles, and where the scan starts.
  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      logic [3:0] e;
      int k;
      e = 4'b0;
      k = -1;
      if (rst) begin
        own[d] = -1; ptr[d] = 0; held[d] = 0;
      end else if (own[d] < 0) begin
        e = req_i;
      end else if (rel_i || model_to(d)) begin
        e = req_i & ~(4'b0001 << own[d]);
        if (e == 4'b0) begin own[d] = -1; held[d] = 0; end
      end else begin
        held[d]++;
      end
      if (!rst && e != 4'b0) begin
        k = pick(e, ptr[d]);
        own[d]  = k;
        held[d] = 1;
        if (mode[d] != 0) ptr[d] = (k + 1) % 4;
      end
    end
    model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int d = 0; d < NDUT; d++) begin
        logic [3:0] eg;
        eg = (own[d] < 0) ? 4'b0 : (4'b0001 << own[d]);
        chk($sformatf("dut%0d gnt", d), 32'(gnt_w[d]), 32'(eg));
        chk($sformatf("dut%0d gnt_valid", d), 32'(vld_w[d]), 32'(own[d] >= 0));
        chk($sformatf("dut%0d gnt_id", d), 32'(id_w[d]), (own[d] < 0) ? 32'd0 : 32'(own[d]));
        chk($sformatf("dut%0d timeout", d), 32'(to_w[d]), 32'(model_to(d)));
      end
    end
  end

  // One clock edge, then the inputs for the following cycle; checks land 2 time units after the edge.
  task automatic step(input logic [3:0] r, input logic rl, input logic rs);
    @(posedge clk);
    #1;
    req_i = r;
    rel_i = rl;
    rst   = rs;
    #1;
  endtask

  logic [3:0] rr_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] to_gnt [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
  logic       to_exp [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; req_i = 4'b1111; rel_i = 1'b0;

    // Reset with everyone requesting, then first grant one cycle after deassertion.
    repeat (3) step(4'b1111, 1'b0, 1'b1);
    chk("reset gnt", 32'(gnt_w[0]), 32'd0);
    chk("reset gnt_valid", 32'(vld_w[0]), 32'd0);
    chk("reset gnt_id", 32'(id_w[0]), 32'd0);
    step(4'b1111, 1'b0, 1'b0);
    chk("still reset gnt", 32'(gnt_w[0]), 32'd0);
    step(4'b1111, 1'b1, 1'b0);
    chk("first rr gnt", 32'(gnt_w[0]), 32'h1);
    chk("first rr id", 32'(id_w[0]), 32'd0);
    chk("first fp gnt", 32'(gnt_w[1]), 32'h1);

    // Round-robin rotation, release every cycle, no bubbles.
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 1'b1, 1'b0);
      chk($sformatf("rr rotate %0d", i), 32'(gnt_w[0]), 32'(rr_seq[i]));
    end

    // Fixed priority with req=1010.
    step(4'b0000, 1'b1, 1'b0);
    step(4'b1010, 1'b0, 1'b0);
    chk("fp idle", 32'(vld_w[1]), 32'd0);
    step(4'b1010, 1'b1, 1'b0);
    chk("fp first", 32'(gnt_w[1]), 32'b0010);
    step(4'b1010, 1'b1, 1'b0);
    chk("fp masked owner", 32'(gnt_w[1]), 32'b1000);
    step(4'b1010, 1'b0, 1'b0);
    chk("fp back", 32'(gnt_w[1]), 32'b0010);

    // Lock: grant survives requests vanishing until release.
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("lock grant", 32'(gnt_w[1]), 32'b0100);
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, 1'b0, 1'b0);
      chk($sformatf("lock hold %0d", i), 32'(gnt_w[1]), 32'b0100);
    end
    step(4'b0000, 1'b1, 1'b0);
    chk("lock before release", 32'(gnt_w[1]), 32'b0100);
    step(4'b0000, 1'b1, 1'b0);
    chk("lock released", 32'(vld_w[1]), 32'd0);
    step(4'b0000, 1'b0, 1'b0);
    chk("idle release ignored", 32'(gnt_w[1]), 32'd0);

    // Timeout with HOLD_MAX=3 and no release.
    step(4'b0011, 1'b0, 1'b1);
    step(4'b0011, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(4'b0011, 1'b0, 1'b0);
      chk($sformatf("hold gnt %0d", i), 32'(gnt_w[2]), 32'(to_gnt[i]));
      chk($sformatf("hold timeout %0d", i), 32'(to_w[2]), 32'(to_exp[i]));
    end
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0011, 1'b1, 1'b0);
    chk("release beats timeout", 32'(to_w[2]), 32'd0);
    chk("release beats timeout gnt", 32'(gnt_w[2]), 32'b0001);
    step(4'b0011, 1'b0, 1'b0);
    chk("after release handover", 32'(gnt_w[2]), 32'b0010);

    // Wrap-around from ptr=3, then mid-grant reset restores ptr to 0.
    step(4'b0100, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0101, 1'b1, 1'b0);
    chk("wrap setup", 32'(gnt_w[0]), 32'b0100);
    step(4'b0101, 1'b0, 1'b1);
    chk("wrap grant", 32'(gnt_w[0]), 32'b0001);
    step(4'b0101, 1'b0, 1'b0);
    chk("mid-grant reset", 32'(gnt_w[0]), 32'd0);
    step(4'b0101, 1'b0, 1'b0);
    chk("after reset ptr0", 32'(gnt_w[0]), 32'b0001);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(4'($urandom), ($urandom_range(2) == 0), ($urandom_range(63) == 0));
    end
    step(4'b0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_prio_arbiter.md
Name: rr_prio_arbiter

Overview:
- Parametrised N-way request arbiter with registered, locking one-hot grants.
- Successor to the combinational LSB-first priority selectors.
- Adds round-robin or fixed-priority mode, grant hold until release, and an optional hold-timeout watchdog.
- Used in the cache and pipeline to arbitrate shared resources (memory port, refill buffer, victim slot) among N requesters.

Parameters:
- N, 4, number of requesters; legal range 1..32.
- MODE, 1, 0 = fixed priority (index 0 highest); 1 = round-robin.
- HOLD_MAX, 0, 0 = no timeout; otherwise the maximum number of consecutive grant cycles (1..65535).
- IDW, (N>1 ? $clog2(N) : 1), width of gnt_id; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  N  request vector, level-sensitive; bit i = requester i.
- release  in  1  current owner is done; sampled only while gnt_valid=1.
- gnt  out  N  registered one-hot grant; all-zero when idle.
- gnt_valid  out  1  registered; equals |gnt.
- gnt_id  out  IDW  registered binary index of the granted bit; 0 when idle.
- timeout  out  1  combinational; high during the final cycle of a grant forcibly ended by HOLD_MAX.

Behaviour:
- Reset: gnt=0, gnt_valid=0, gnt_id=0, hold counter=0, rotation pointer ptr=0, state=IDLE. Reset applied mid-grant drops the grant on the next edge with no release needed.
- States:
  - IDLE: gnt=0.
  - GRANT: gnt holds exactly one bit.
- Arbitration function: scan from index ptr upward, wrapping N-1 -> 0; the first set bit of the eligible vector wins.
  - MODE=0: ptr is always 0, so this is pure LSB-first priority.
- IDLE -> GRANT:
  - Taken when |req=1 at an edge; eligible vector = req.
  - gnt and gnt_id are valid the cycle after req is seen (latency 1).
  - If |req=0, stay in IDLE.
- GRANT hold (lock):
  - gnt is held regardless of req changes, including the owner dropping its req, until an end event.
  - An end event is release=1, or timeout=1.
- End event with others requesting: eligible vector = req with the current owner's bit masked. If non-zero, the new winner's gnt appears on the next edge (back-to-back, no bubble).
- End event with no other requester: go to IDLE (gnt=0). The owner can win again from IDLE one cycle later.
- Rotation pointer:
  - On every new grant to index k with MODE=1, ptr <= (k+1) mod N. When k=N-1, ptr wraps to 0.
  - With N=1, ptr is always 0.
- Release outside a grant: release while in IDLE is ignored and has no effect on state or ptr.
- Hold counter (when HOLD_MAX>0):
  - Clears on every new grant and increments each GRANT cycle.
  - timeout = (counter==HOLD_MAX-1) && !release, so the grant lasts at most HOLD_MAX cycles.
  - When release and the timeout condition coincide, release wins and timeout stays 0.
  - HOLD_MAX=0: the counter logic is removed and timeout is tied to 0.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_id == the encoded gnt.
  - A grant is never issued to a requester whose req was 0 at the arbitration edge.

Test Plan (N=4 unless noted):
1. Reset: hold rst=1 for 3 cycles with req=4'b1111 → gnt=0, gnt_valid=0, gnt_id=0. Deassert rst → gnt=4'b0001, gnt_id=0 one cycle later.
2. Round-robin, MODE=1, req=4'b1111 held, release pulsed every grant cycle → gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles with no idle cycle.
3. Fixed priority, MODE=0, req=4'b1010:
   - first grant → 0010;
   - release with req unchanged → 1000 (owner masked);
   - release again → 0010.
4. Lock:
   - gnt=0100, then req=0000 for 10 cycles with release=0 → gnt stays 0100;
   - release=1 → IDLE next cycle;
   - a further release pulse while idle → no change.
5. Timeout, HOLD_MAX=3, MODE=1:
   - req=4'b0011, release never asserted → 0001 for exactly 3 cycles, timeout=1 in the third, then 0010 for 3 cycles.
   - Release and timeout asserted in the same cycle → timeout=0.
6. Wrap and mid-grant reset:
   - after a grant to index 2 (ptr=3), req=0101 → gnt 0001 via wrap-around;
   - assert rst during that grant → gnt=0 next edge, and the next arbitration of req=0101 yields 0001 (ptr reset to 0).
